// File: rtl/bist_response_compactor_pkg.sv
// Shared types, default polynomials and the MISR step function used by the
// BIST response compactor and its MISR datapath.
package bist_response_compactor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [7:0]  POLY8  = 8'h1D;
   localparam logic [15:0] POLY16 = 16'h100B;

   // Widest signature misr_next() can fold; narrower widths are masked down.
   localparam int unsigned MAX_W = 64;

   function automatic logic [MAX_W-1:0] misr_next(
      input logic [MAX_W-1:0] sig,
      input logic [MAX_W-1:0] data,
      input logic [MAX_W-1:0] poly,
      input int unsigned      width
   );
      logic [MAX_W-1:0] mask;
      logic             msb;
      mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
      msb  = |(sig & (MAX_W'(1) << (width - 1)));
      return ((sig << 1) ^ (msb ? poly : '0) ^ data) & mask;
   endfunction

endpackage

// File: rtl/bist_response_compactor_misr_core.sv
// MISR signature register: loads SEED, or folds one data word per enabled
// cycle through the shift/XOR feedback. No control logic lives here.
module bist_response_compactor_misr_core
   import bist_response_compactor_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(POLY8),
   parameter logic [WIDTH-1:0] SEED  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             enable_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] signature_o,
   output logic [WIDTH-1:0] sig_next_o
);

   logic [WIDTH-1:0] sig_q;
   logic [WIDTH-1:0] sig_d;
   logic [WIDTH-1:0] folded;

   assign folded = WIDTH'(misr_next(MAX_W'(sig_q), MAX_W'(data_i), MAX_W'(POLY), WIDTH));

   always_comb begin
      sig_d = sig_q;
      if (load_i) begin
         sig_d = SEED;
      end else if (enable_i) begin
         sig_d = folded;
      end
   end

   // Reset clears to zero; SEED is only applied when a run is started.
   always_ff @(posedge clk) begin
      if (rst) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign signature_o = sig_q;
   assign sig_next_o  = sig_d;

endmodule

// File: rtl/bist_response_compactor.sv
// BIST response compactor: runs the MISR over PATTERNS valid CUT responses,
// then compares the final signature with golden and holds the verdict.
module bist_response_compactor
   import bist_response_compactor_pkg::*;
#(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] POLY     = (WIDTH == 16) ? WIDTH'(POLY16) : WIDTH'(POLY8),
   parameter logic [WIDTH-1:0] SEED     = '0,
   parameter int               PATTERNS = 256,
   localparam int              CW       = $clog2(PATTERNS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             resp_valid,
   input  logic [WIDTH-1:0] resp_data,
   input  logic [WIDTH-1:0] golden,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH-1:0] signature,
   output logic [CW-1:0]    resp_count
);

   state_e           state_q;
   state_e           state_d;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic             pass_q;
   logic             pass_d;
   logic [WIDTH-1:0] sigNext;
   logic             startOk;
   logic             absorb;
   logic             lastResp;

   assign startOk  = start && (state_q != RUN);
   assign absorb   = resp_valid && (state_q == RUN);
   assign lastResp = absorb && (count_q == CW'(PATTERNS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)    state_d = RUN;
         RUN:     if (lastResp) state_d = DONE;
         DONE:    if (start)    state_d = RUN;
         default:               state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
   end

   // The verdict is taken from the signature being written on the final edge.
   always_comb begin
      count_d = count_q;
      pass_d  = pass_q;
      if (startOk) begin
         count_d = '0;
         pass_d  = 1'b0;
      end else if (absorb) begin
         count_d = count_q + CW'(1);
         if (lastResp) begin
            pass_d = (sigNext == golden);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         pass_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         pass_q  <= pass_d;
      end
   end

   bist_response_compactor_misr_core #(
      .WIDTH (WIDTH),
      .POLY  (POLY),
      .SEED  (SEED)
   ) misr (
      .clk         (clk),
      .rst         (rst),
      .load_i      (startOk),
      .enable_i    (absorb),
      .data_i      (resp_data),
      .signature_o (signature),
      .sig_next_o  (sigNext)
   );

   assign pass       = pass_q;
   assign resp_count = count_q;

endmodule

// File: tb/tb_bist_response_compactor.sv
// Self-checking bench: four compactors (PATTERNS = 1, 2, 256, 4) share data
// and reset, each with its own start; a scoreboard checks every cycle.
module tb_bist_response_compactor;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] startV;
   logic       respValid;
   logic [7:0] respData;
   logic [7:0] golden;

   logic [3:0] busyV;
   logic [3:0] doneV;
   logic [3:0] passV;
   logic [7:0] sigV [4];
   logic [8:0] cntV [4];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : gInst
      localparam int P = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 256 : 4;
      logic [$clog2(P+1)-1:0] cnt;
      bist_response_compactor #(
         .WIDTH    (8),
         .POLY     (8'h1D),
         .SEED     (8'h00),
         .PATTERNS (P)
      ) dut (
         .clk        (clk),
         .rst        (rst),
         .start      (startV[g]),
         .resp_valid (respValid),
         .resp_data  (respData),
         .golden     (golden),
         .busy       (busyV[g]),
         .done       (doneV[g]),
         .pass       (passV[g]),
         .signature  (sigV[g]),
         .resp_count (cnt)
      );
      assign cntV[g] = 9'(cnt);
   end

   typedef struct {
      int         inst;
      logic       busy;
      logic       done;
      logic       pass;
      logic [7:0] sig;
      int         cnt;
   } exp_t;

   exp_t       sbq[$];
   int         pat[4] = '{1, 2, 256, 4};
   bit         mRun[4];
   bit         mDone[4];
   bit         mPass[4];
   logic [7:0] mSig[4];
   int         mCnt[4];

   // Reference step written as polynomial multiply-by-x modulo x^8+x^4+x^3+x^2+1.
   function automatic logic [7:0] modelNext(input logic [7:0] s, input logic [7:0] d);
      logic [8:0] t;
      t = {s, 1'b0};
      if (t[8]) t = t ^ 9'h11D;
      return t[7:0] ^ d;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] st, input logic v, input logic [7:0] d,
                                input logic [7:0] g, input logic r);
      exp_t e;
      rst       = r;
      startV    = st;
      respValid = v;
      respData  = d;
      golden    = g;
      for (int i = 0; i < 4; i++) begin
         if (r) begin
            mRun[i] = 0; mDone[i] = 0; mPass[i] = 0; mSig[i] = 8'h00; mCnt[i] = 0;
         end else if (st[i] && !mRun[i]) begin
            mRun[i] = 1; mDone[i] = 0; mPass[i] = 0; mSig[i] = 8'h00; mCnt[i] = 0;
         end else if (mRun[i] && v) begin
            mSig[i] = modelNext(mSig[i], d);
            mCnt[i]++;
            if (mCnt[i] == pat[i]) begin
               mRun[i]  = 0;
               mDone[i] = 1;
               mPass[i] = (mSig[i] == g);
            end
         end
         e.inst = i; e.busy = mRun[i]; e.done = mDone[i]; e.pass = mPass[i];
         e.sig = mSig[i]; e.cnt = mCnt[i];
         sbq.push_back(e);
      end
      @(posedge clk);
      #1;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         checkOutput($sformatf("i%0d busy", e.inst), 32'(busyV[e.inst]), 32'(e.busy));
         checkOutput($sformatf("i%0d done", e.inst), 32'(doneV[e.inst]), 32'(e.done));
         checkOutput($sformatf("i%0d pass", e.inst), 32'(passV[e.inst]), 32'(e.pass));
         checkOutput($sformatf("i%0d sig", e.inst),  32'(sigV[e.inst]),  32'(e.sig));
         checkOutput($sformatf("i%0d cnt", e.inst),  32'(cntV[e.inst]),  32'(e.cnt));
      end
   endtask

   initial begin
      logic [7:0] dat [4];
      logic [7:0] refSig;

      // Reset: every instance idle with zeroed outputs.
      applyStimulus(4'b0000, 1'b0, 8'h00, 8'h00, 1'b1);
      applyStimulus(4'b0000, 1'b1, 8'h5A, 8'h00, 1'b1);
      applyStimulus(4'b0000, 1'b0, 8'h00, 8'h00, 1'b0);
      checkOutput("reset sig", 32'(sigV[3]), 32'h00);

      // PATTERNS=1: one response, matching golden.
      applyStimulus(4'b0001, 1'b0, 8'h00, 8'h00, 1'b0);
      applyStimulus(4'b0000, 1'b1, 8'h01, 8'h01, 1'b0);
      checkOutput("t1 done", 32'(doneV[0]), 32'd1);
      checkOutput("t1 pass", 32'(passV[0]), 32'd1);
      checkOutput("t1 sig",  32'(sigV[0]),  32'h01);
      checkOutput("t1 cnt",  32'(cntV[0]),  32'd1);

      // PATTERNS=2 with a three-cycle gap and a wrong golden.
      applyStimulus(4'b0010, 1'b0, 8'h00, 8'h1C, 1'b0);
      applyStimulus(4'b0000, 1'b1, 8'h80, 8'h1C, 1'b0);
      checkOutput("t2 sig first", 32'(sigV[1]), 32'h80);
      for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 1'b0, 8'hFF, 8'h1C, 1'b0);
      applyStimulus(4'b0000, 1'b1, 8'h00, 8'h1C, 1'b0);
      checkOutput("t2 sig",  32'(sigV[1]),  32'h1D);
      checkOutput("t2 done", 32'(doneV[1]), 32'd1);
      checkOutput("t2 pass", 32'(passV[1]), 32'd0);
      checkOutput("t1 frozen sig", 32'(sigV[0]), 32'h01);

      // PATTERNS=256 all-zero responses.
      applyStimulus(4'b0100, 1'b0, 8'h00, 8'h00, 1'b0);
      for (int i = 0; i < 255; i++) applyStimulus(4'b0000, 1'b1, 8'h00, 8'h00, 1'b0);
      checkOutput("t3 done early", 32'(doneV[2]), 32'd0);
      applyStimulus(4'b0000, 1'b1, 8'h00, 8'h00, 1'b0);
      checkOutput("t3 done", 32'(doneV[2]), 32'd1);
      checkOutput("t3 pass", 32'(passV[2]), 32'd1);
      checkOutput("t3 cnt",  32'(cntV[2]),  32'd256);
      applyStimulus(4'b0000, 1'b0, 8'h00, 8'h00, 1'b0);
      checkOutput("t3 busy after", 32'(busyV[2]), 32'd0);

      // Reset after 3 of 4 responses, then an uninterrupted rerun.
      for (int i = 0; i < 4; i++) dat[i] = 8'($urandom_range(0, 255));
      applyStimulus(4'b1000, 1'b0, 8'h00, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 1'b1, dat[i], 8'h00, 1'b0);
      applyStimulus(4'b0000, 1'b1, dat[3], 8'h00, 1'b1);
      checkOutput("t4 rst sig", 32'(sigV[3]), 32'h00);
      checkOutput("t4 rst cnt", 32'(cntV[3]), 32'd0);
      applyStimulus(4'b1000, 1'b0, 8'h00, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(4'b0000, 1'b1, dat[i], 8'h00, 1'b0);
      refSig = mSig[3];

      // Restart from DONE, mid-run start pulse, valid held while in DONE.
      applyStimulus(4'b1000, 1'b0, 8'h00, refSig, 1'b0);
      applyStimulus(4'b0000, 1'b1, dat[0], refSig, 1'b0);
      applyStimulus(4'b0000, 1'b1, dat[1], refSig, 1'b0);
      applyStimulus(4'b1000, 1'b0, 8'h00, refSig, 1'b0);
      checkOutput("t5 no restart cnt", 32'(cntV[3]), 32'd2);
      applyStimulus(4'b1000, 1'b1, dat[2], refSig, 1'b0);
      applyStimulus(4'b0000, 1'b1, dat[3], refSig, 1'b0);
      checkOutput("t5 same sig", 32'(sigV[3]), 32'(refSig));
      checkOutput("t5 pass", 32'(passV[3]), 32'd1);
      applyStimulus(4'b0000, 1'b1, 8'h3C, 8'h00, 1'b0);
      applyStimulus(4'b0000, 1'b1, 8'hC3, 8'h00, 1'b0);
      checkOutput("t5 frozen sig", 32'(sigV[3]), 32'(refSig));
      checkOutput("t5 frozen cnt", 32'(cntV[3]), 32'd4);

      // Start in DONE with a simultaneous valid word that must be dropped.
      applyStimulus(4'b1000, 1'b1, 8'hAA, 8'h00, 1'b0);
      checkOutput("t6 sig",  32'(sigV[3]),  32'h00);
      checkOutput("t6 cnt",  32'(cntV[3]),  32'd0);
      checkOutput("t6 done", 32'(doneV[3]), 32'd0);
      checkOutput("t6 busy", 32'(busyV[3]), 32'd1);
      applyStimulus(4'b0000, 1'b0, 8'h00, 8'h00, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
